// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and helpers for the UART baud/oversample tick generator.
//   MIN_DIV      : smallest effective divisor; smaller requests are clamped
//   DEF_DIV_INT  : integer divisor loaded at reset
//   DEF_DIV_FRAC : fractional divisor loaded at reset (1/2^FRAC_W units)
//   clog2_min1() : ceil(log2(n)) but never below 1, for counter widths
// 54 + 4/16 from a 100 MHz clock gives 115200 baud with x16 oversampling.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned MIN_DIV      = 2;
    localparam int unsigned DEF_DIV_INT  = 54;
    localparam int unsigned DEF_DIV_FRAC = 4;

    // Width of a counter holding 0..n-1, at least one bit wide.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 3) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_tick_gen_frac_interval_counter.sv
// ---------------------------------------------------------------------------
// frac_interval_counter
// Fractional-N interval down-counter. Each interval lasts eff(div_int) or
// eff(div_int)+1 enabled cycles; the extra cycle is inserted whenever the
// fractional accumulator carries, so 2^FRAC_W intervals take exactly
// 2^FRAC_W*div_int + div_frac cycles. A divisor written with div_load is held
// in a shadow register and only switched in at an interval boundary (or on
// sync_clr, or immediately while counting is disabled).
//
// Ports
//   clk, rst   : system clock, asynchronous active-high reset
//   en         : counting enable; cnt/frac_acc hold while low
//   div_int    : requested integer divisor
//   div_frac   : requested fractional divisor
//   div_load   : one-cycle request to capture div_int/div_frac
//   sync_clr   : restart the interval with the active divisor, no strobe
//   os_tick    : registered one-cycle strobe at each interval end
//   div_ack    : registered pulse in the cycle a new divisor is active
//   tick_c     : combinational "os_tick will be high next cycle"
// ---------------------------------------------------------------------------
module frac_interval_counter
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned RST_DIV_INT  = 54,
    parameter int unsigned RST_DIV_FRAC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              sync_clr,
    output logic              os_tick,
    output logic              div_ack,
    output logic              tick_c
);

    localparam int unsigned CW1     = CNT_W + 1;
    localparam int unsigned FW1     = FRAC_W + 1;
    localparam int unsigned RST_EFF = (RST_DIV_INT < MIN_DIV) ? MIN_DIV : RST_DIV_INT;

    localparam logic [CNT_W-1:0]  RST_CNT  = CNT_W'(RST_EFF - 1);
    localparam logic [CNT_W-1:0]  RST_INT  = CNT_W'(RST_DIV_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV_FRAC);

    // Clamp so an interval is never shorter than two cycles.
    function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : d;
    endfunction

    // State
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
    logic [CNT_W-1:0]  act_int_q,  act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [CNT_W-1:0]  shd_int_q,  shd_int_d;
    logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
    logic              pend_q,     pend_d;
    logic              os_tick_q,  os_tick_d;
    logic              div_ack_q,  div_ack_d;

    // Combinational helpers
    logic              reload_c;
    logic              apply_c;
    logic [CNT_W-1:0]  new_int_c;
    logic [FRAC_W-1:0] new_frac_c;
    logic [CNT_W-1:0]  use_int_c;
    logic [FRAC_W-1:0] use_frac_c;
    logic [CNT_W-1:0]  eff_c;
    logic [FW1-1:0]    frac_sum_c;
    logic [CW1-1:0]    reload_wide_c;
    logic [CNT_W-1:0]  reload_cnt_c;

    // Next-state: divisor hand-over, interval counting and reload.
    always_comb begin
        cnt_d      = cnt_q;
        frac_acc_d = frac_acc_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        pend_d     = pend_q;
        os_tick_d  = 1'b0;
        div_ack_d  = 1'b0;

        // sync_clr pre-empts an interval end that would otherwise fire.
        reload_c = en && !sync_clr && (cnt_q == '0);

        // A new divisor takes effect at a boundary (reload or sync_clr), or
        // straight away when counting is stopped so software is not stalled.
        apply_c = ((pend_q || div_load) && (sync_clr || reload_c)) ||
                  (pend_q && !en);

        // A load in the same cycle overrides an older shadow value.
        new_int_c  = div_load ? div_int  : shd_int_q;
        new_frac_c = div_load ? div_frac : shd_frac_q;
        use_int_c  = apply_c ? new_int_c  : act_int_q;
        use_frac_c = apply_c ? new_frac_c : act_frac_q;
        eff_c      = eff_div(use_int_c);

        frac_sum_c    = FW1'(frac_acc_q) + FW1'(use_frac_c);
        // One bit wider so all-ones plus a carry cannot wrap to a short count.
        reload_wide_c = CW1'(eff_c) + CW1'(frac_sum_c[FRAC_W]) - CW1'(1);
        reload_cnt_c  = reload_wide_c[CNT_W] ? '1 : reload_wide_c[CNT_W-1:0];

        if (apply_c) begin
            act_int_d  = use_int_c;
            act_frac_d = use_frac_c;
            pend_d     = 1'b0;
            div_ack_d  = 1'b1;
        end else if (div_load) begin
            shd_int_d  = div_int;
            shd_frac_d = div_frac;
            pend_d     = 1'b1;
        end

        if (sync_clr) begin
            frac_acc_d = '0;
            cnt_d      = eff_c - CNT_W'(1);
        end else if (reload_c) begin
            frac_acc_d = frac_sum_c[FRAC_W-1:0];
            cnt_d      = reload_cnt_c;
            os_tick_d  = 1'b1;
        end else if (en) begin
            cnt_d      = cnt_q - CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= RST_CNT;
            frac_acc_q <= '0;
            act_int_q  <= RST_INT;
            act_frac_q <= RST_FRAC;
            shd_int_q  <= '0;
            shd_frac_q <= '0;
            pend_q     <= 1'b0;
            os_tick_q  <= 1'b0;
            div_ack_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            frac_acc_q <= frac_acc_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            pend_q     <= pend_d;
            os_tick_q  <= os_tick_d;
            div_ack_q  <= div_ack_d;
        end
    end

    assign os_tick = os_tick_q;
    assign div_ack = div_ack_q;
    assign tick_c  = reload_c;

endmodule : frac_interval_counter

// File: rtl/uart_baud_tick_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_tick_gen
// Baud-rate clock-enable generator for the UART TX/RX engines. Produces
// single-cycle strobes in the system clock domain: os_tick at the oversample
// rate, mid_tick at each bit centre and bit_tick at each bit boundary.
//
// Ports
//   clk, rst   : system clock, asynchronous active-high reset
//   en         : counting enable; all state holds, no strobes while low
//   div_int    : requested integer divisor (cycles per os_tick)
//   div_frac   : requested fractional divisor, 1/2^FRAC_W units
//   div_load   : one-cycle request to capture div_int/div_frac
//   sync_clr   : restart interval and bit phase (start-bit alignment)
//   os_tick    : oversample strobe
//   mid_tick   : strobe with the os_tick reaching the bit centre
//   bit_tick   : strobe with the os_tick that wraps the bit phase
//   os_phase   : os_ticks counted within the current bit
//   div_ack    : pulse in the cycle a new divisor becomes active
// ---------------------------------------------------------------------------
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DEF_DIV_INT  = uart_pkg::DEF_DIV_INT,
    parameter int unsigned DEF_DIV_FRAC = uart_pkg::DEF_DIV_FRAC
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [CNT_W-1:0]                    div_int,
    input  logic [FRAC_W-1:0]                   div_frac,
    input  logic                                div_load,
    input  logic                                sync_clr,
    output logic                                os_tick,
    output logic                                mid_tick,
    output logic                                bit_tick,
    output logic [clog2_min1(OVERSAMPLE)-1:0]   os_phase,
    output logic                                div_ack
);

    localparam int unsigned     PH_W    = clog2_min1(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);

    logic            tick_c;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [PH_W-1:0] ph_next_c;
    logic            mid_q,   mid_d;
    logic            bit_q,   bit_d;

    // Oversample interval generator.
    frac_interval_counter #(
        .CNT_W        (CNT_W),
        .FRAC_W       (FRAC_W),
        .RST_DIV_INT  (DEF_DIV_INT),
        .RST_DIV_FRAC (DEF_DIV_FRAC)
    ) u_interval (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .sync_clr (sync_clr),
        .os_tick  (os_tick),
        .div_ack  (div_ack),
        .tick_c   (tick_c)
    );

    // Bit phase: registered on the same edge as os_tick so that os_phase,
    // mid_tick and bit_tick all line up with the os_tick they belong to.
    always_comb begin
        phase_d   = phase_q;
        mid_d     = 1'b0;
        bit_d     = 1'b0;
        ph_next_c = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);

        if (sync_clr) begin
            phase_d = '0;
        end else if (tick_c) begin
            phase_d = ph_next_c;
            bit_d   = (phase_q == PH_LAST);
            mid_d   = (ph_next_c == PH_MID);
        end
    end

    // Phase and decode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            mid_q   <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            mid_q   <= mid_d;
            bit_q   <= bit_d;
        end
    end

    assign os_phase = phase_q;
    assign mid_tick = mid_q;
    assign bit_tick = bit_q;

endmodule : uart_baud_tick_gen

// File: doc/uart_baud_tick_gen.md
Name: uart_baud_tick_gen

Overview:
- Parametrised successor to the square-wave clock divider.
- Produces single-cycle clock-enable strobes (oversample, mid-bit, bit) in the system clock domain instead of a derived clock.
- Divisor is runtime-programmable, with a fractional part for accurate baud rates from arbitrary system clocks.
- Sits between the register block and the UART TX/RX engines; sync_clr lets RX align the bit phase to a start-bit edge.

Parameters:
- CNT_W, 16, width of the integer divisor and of the down-counter.
- FRAC_W, 4, width of the fractional divisor and of the accumulator.
- OVERSAMPLE, 16, os_ticks per bit; must be >= 2.
- DEF_DIV_INT, 54, integer divisor loaded at reset.
- DEF_DIV_FRAC, 4, fractional divisor loaded at reset. 54 + 4/16 gives 115200 baud x16 from 100 MHz.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  counting enable; when low, all state holds and no strobes are issued.
- div_int  in  CNT_W  requested integer divisor.
- div_frac  in  FRAC_W  requested fractional divisor, in units of 1/2^FRAC_W.
- div_load  in  1  one-cycle request to capture div_int and div_frac.
- sync_clr  in  1  restarts the interval and the bit phase.
- os_tick  out  1  oversample strobe.
- mid_tick  out  1  strobe at the bit centre.
- bit_tick  out  1  strobe at the bit boundary.
- os_phase  out  $clog2(OVERSAMPLE)  count of os_ticks within the current bit.
- div_ack  out  1  pulses in the cycle a new divisor becomes active.

Behaviour:
- Reset values:
  - all strobes, div_ack and os_phase = 0
  - active divisor = DEF_DIV_INT / DEF_DIV_FRAC
  - pending flag cleared; frac_acc = 0
  - cnt = eff(DEF_DIV_INT) - 1
- Reset mid-operation discards any pending load and restarts from these values.
- All outputs are registered.
- eff(x) = max(x, 2). A divisor of 0 or 1 is clamped to 2, so os_tick is never stuck high.
- Interval, for each cycle with en=1:
  - If cnt != 0: cnt <= cnt - 1.
  - If cnt == 0: os_tick <= 1 next cycle, then reload.
  - Reload computes {carry, frac_acc} <= frac_acc + div_frac (FRAC_W+1 bit add) and cnt <= eff(div_int) + carry - 1.
  - Result: each interval is div_int or div_int+1 cycles. Over 2^FRAC_W intervals the total is exactly 2^FRAC_W*div_int + div_frac cycles.
- Reload arithmetic is CNT_W+1 bits wide. A div_int of all-ones plus a carry must not wrap; saturate cnt at all-ones.
- After reset with en held high, the first os_tick is high in the cycle following the eff(DEF_DIV_INT)-th enabled edge.
- Phase counter:
  - Each os_tick advances os_phase modulo OVERSAMPLE; os_phase updates in the same cycle os_tick is high.
  - bit_tick is high with the os_tick that wraps os_phase to 0.
  - mid_tick is high with the os_tick that makes os_phase == OVERSAMPLE/2 (integer division).
- en=0:
  - cnt, frac_acc and os_phase hold.
  - All strobes are low.
  - A pending load is applied on the next cycle regardless of en.
- div_load:
  - Captures the inputs into shadow registers and sets pending.
  - With en=1, the shadow is applied at the next reload (the cnt==0 cycle), so no truncated interval occurs; div_ack pulses that cycle.
  - A second div_load while pending overwrites the shadow; the last one wins, and only one div_ack is issued.
  - div_load coinciding with a reload cycle is applied at that reload.
- sync_clr (priority over the tick):
  - Applies any pending divisor, with div_ack.
  - Sets frac_acc <= 0, os_phase <= 0, cnt <= eff(div_int) - 1 using the active divisor.
  - No strobe is issued in the following cycle, even if cnt was 0.
  - Works when en=0.
- Simultaneous rst and anything else: rst wins.

Decomposition:
- Shared package uart_pkg holds:
  - MIN_DIV = 2
  - default divisor constants DEF_DIV_INT / DEF_DIV_FRAC
  - function clog2_min1 for phase width, returning at least 1
- One natural sub-module: frac_interval_counter. It contains cnt, frac_acc, the shadow/pending logic and eff() clamping, and emits os_tick and div_ack.
- The top level adds the phase counter and the mid/bit decode.

Test Plan:
- Defaults, en=1 from reset:
  - os_tick intervals repeat 54, 54, 54, 55.
  - bit_tick period is exactly 868 cycles.
  - mid_tick comes 8 os_ticks after each bit_tick.
- div_load of div_int=10, div_frac=0 issued mid-interval:
  - The current interval completes at its old length.
  - div_ack pulses on the reload cycle.
  - All subsequent intervals are 10 cycles.
- div_load of div_int=0, then div_int=1, back-to-back while pending:
  - Exactly one div_ack.
  - Intervals are 2 cycles.
  - os_tick toggles 1,0,1,0.
- sync_clr asserted in the cnt==0 cycle with os_phase=7:
  - No os_tick in the next cycle; os_phase reads 0.
  - The next os_tick comes after a full 54 cycles (frac_acc cleared).
- en deasserted for 100 cycles mid-interval:
  - No strobes.
  - After re-enable, the remaining count resumes, and the interval sum equals the original length plus 0.
- rst pulsed mid-bit after a pending div_load:
  - All outputs are 0.
  - The pending load is discarded, with no div_ack.
  - Timing returns to the 54/54/54/55 pattern.
